// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
//   Bundles the sequencer's status inputs and datapath control outputs.
//
//   slave  modport : the control FSM (consumes status, drives controls)
//   master modport : the datapath / environment (drives status, consumes controls)
//
//   Status   : en, opcode[5:0], zero, mem_ready
//   Controls : pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
//              mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//              alu_op[1:0], pc_source[1:0]
//   Status out: instr_done, illegal_op, retired[CNT_W-1:0], state[3:0]
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;

  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_2_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;

  modport slave (
    input  en, opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, retired, state
  );

  modport master (
    output en, opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, retired, state
  );
endinterface

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Sequencing FSM for a multicycle MIPS datapath. Every instruction walks
//   FETCH -> DECODE -> (execute / memory / writeback states) and the block
//   drives ALU, memory, IR, PC and register-file controls for each state.
//   Memory accesses stall on mem_ready; completed instructions are counted in
//   retired; unsupported opcodes set the sticky illegal_op flag.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous reset, active-low
//   bus    : multicycle_control_if.slave (status in, controls out)
//
// State encoding (bus.state, debug only)
//   0 IDLE  1 FETCH  2 DECODE  3 EXEC_R  4 R_WB  5 EXEC_I  6 I_WB
//   7 MEM_ADDR  8 MEM_RD  9 MEM_WB  10 MEM_WR  11 BRANCH  12 JUMP  13 BAD
//
// Moore controls are registered: they are decoded from the next state and
// loaded together with the state register. The only controls that also
// depend on the current input are the FETCH strobes (ir_write, pc_write) and
// the MEM_WR completion pulse, which are qualified by mem_ready.
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int         CNT_W         = 32,
  parameter logic [1:0] ADD_OPCODE    = 2'd0,
  parameter logic [1:0] SUB_OPCODE    = 2'd1,
  parameter logic [1:0] R_TYPE_OPCODE = 2'd2
) (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    R_WB     = 4'd4,
    EXEC_I   = 4'd5,
    I_WB     = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    MEM_WB   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    BAD      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // Registered per-state control word. fetch and wr_done are internal
  // qualifiers combined with mem_ready at the output.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       fetch;
    logic       mem_2_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       done;
    logic       wr_done;
  } ctl_t;

  state_t           state_q, state_d;
  ctl_t             ctl_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  logic             instr_done;

  // Control word for a given state; anything not set here stays 0.
  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c        = '0;
    c.alu_op = ADD_OPCODE;
    case (s)
      FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE: begin
        // Branch target precomputed while the opcode is decoded
        c.alu_src_b = 2'b11;
      end
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b00;
        c.alu_op    = R_TYPE_OPCODE;
      end
      R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      EXEC_I, MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      I_WB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      MEM_RD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      MEM_WB: begin
        c.mem_2_reg = 1'b1;
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
      MEM_WR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        c.wr_done   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = 2'b00;
        c.alu_op        = SUB_OPCODE;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.done          = 1'b1;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.done      = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.en) state_d = FETCH;
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:      state_d = EXEC_R;
          OP_ADDI:       state_d = EXEC_I;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BRANCH;
          OP_J:          state_d = JUMP;
          default:       state_d = BAD;
        endcase
      end
      EXEC_R:   state_d = R_WB;
      EXEC_I:   state_d = I_WB;
      MEM_ADDR: state_d = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (bus.mem_ready) state_d = MEM_WB;
      MEM_WR:   if (bus.mem_ready) state_d = bus.en ? FETCH : IDLE;
      // Last state of an instruction: en is only consulted here, so a
      // deasserted en lets the instruction in flight finish first.
      R_WB, I_WB, MEM_WB, BRANCH, JUMP, BAD:
                state_d = bus.en ? FETCH : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign instr_done = ctl_q.done | (ctl_q.wr_done & bus.mem_ready);

  // State / control register stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ctl_q     <= decode(IDLE);
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode(state_d);
      // Set on entry so the flag is already high while sitting in BAD
      if (state_d == BAD) illegal_q <= 1'b1;
      if (instr_done)     retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Output stage
  assign bus.pc_write      = ctl_q.pc_write | (ctl_q.fetch & bus.mem_ready);
  assign bus.pc_write_cond = ctl_q.pc_write_cond;
  assign bus.iord          = ctl_q.iord;
  assign bus.mem_read      = ctl_q.mem_read;
  assign bus.mem_write     = ctl_q.mem_write;
  assign bus.ir_write      = ctl_q.fetch & bus.mem_ready;
  assign bus.mem_2_reg     = ctl_q.mem_2_reg;
  assign bus.reg_dst       = ctl_q.reg_dst;
  assign bus.reg_write     = ctl_q.reg_write;
  assign bus.alu_src_a     = ctl_q.alu_src_a;
  assign bus.alu_src_b     = ctl_q.alu_src_b;
  assign bus.alu_op        = ctl_q.alu_op;
  assign bus.pc_source     = ctl_q.pc_source;
  assign bus.instr_done    = instr_done;
  assign bus.illegal_op    = illegal_q;
  assign bus.retired       = retired_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
module tb_multicycle_control;

  localparam logic [1:0] A_ADD = 2'd0;
  localparam logic [1:0] A_SUB = 2'd1;
  localparam logic [1:0] A_R   = 2'd2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus();

  multicycle_control #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_2_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctl_t;

  // One expected clock cycle: inputs to drive and outputs to expect
  typedef struct {
    ctl_t        exp;
    logic        mr;
    logic        en;
    logic [5:0]  op;
    logic [31:0] ret;
    logic        ill;
  } step_t;

  step_t       q[$];
  int          checks = 0;
  int          passed = 0;
  logic [31:0] m_ret;
  logic        m_ill;

  function automatic ctl_t observed();
    ctl_t c;
    c.pc_write      = bus.pc_write;
    c.pc_write_cond = bus.pc_write_cond;
    c.iord          = bus.iord;
    c.mem_read      = bus.mem_read;
    c.mem_write     = bus.mem_write;
    c.ir_write      = bus.ir_write;
    c.mem_2_reg     = bus.mem_2_reg;
    c.reg_dst       = bus.reg_dst;
    c.reg_write     = bus.reg_write;
    c.alu_src_a     = bus.alu_src_a;
    c.alu_src_b     = bus.alu_src_b;
    c.alu_op        = bus.alu_op;
    c.pc_source     = bus.pc_source;
    c.instr_done    = bus.instr_done;
    return c;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- reference model: instruction -> cycle list ----------------
  task automatic push(input ctl_t c, input logic mr, input logic e,
                      input logic [5:0] op, input bit done);
    step_t s;
    s.exp = c; s.mr = mr; s.en = e; s.op = op; s.ret = m_ret; s.ill = m_ill;
    q.push_back(s);
    if (done) m_ret = m_ret + 32'd1;
  endtask

  task automatic add_idle(input int n, input logic e);
    for (int i = 0; i < n; i++) push('0, rnd_bit(), e, 6'($urandom), 1'b0);
  endtask

  // wf/wm: mem_ready=0 cycles in FETCH / data access; en is 1 for the first
  // 'drop' cycles of the instruction and 0 afterwards.
  task automatic add_instr(input logic [5:0] op, input int wf, input int wm,
                           input int drop, output logic last_en);
    ctl_t c;
    int   k;
    k = 0;
    for (int i = 0; i <= wf; i++) begin
      c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = A_ADD;
      if (i == wf) begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
      push(c, (i == wf), (k < drop), 6'($urandom), 1'b0); k++;
    end
    c = '0; c.alu_src_b = 2'b11; c.alu_op = A_ADD;
    push(c, rnd_bit(), (k < drop), op, 1'b0); k++;
    case (op)
      6'h00: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b00; c.alu_op = A_R;
        push(c, rnd_bit(), (k < drop), op, 1'b0); k++;
        c = '0; c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
        push(c, rnd_bit(), (k < drop), op, 1'b1); k++;
      end
      6'h08: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        push(c, rnd_bit(), (k < drop), op, 1'b0); k++;
        c = '0; c.reg_write = 1'b1; c.instr_done = 1'b1;
        push(c, rnd_bit(), (k < drop), op, 1'b1); k++;
      end
      6'h23, 6'h2B: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        push(c, rnd_bit(), (k < drop), op, 1'b0); k++;
        for (int i = 0; i <= wm; i++) begin
          c = '0; c.iord = 1'b1;
          if (op == 6'h23) c.mem_read = 1'b1; else c.mem_write = 1'b1;
          if (op == 6'h2B && i == wm) c.instr_done = 1'b1;
          push(c, (i == wm), (k < drop), op, (op == 6'h2B && i == wm)); k++;
        end
        if (op == 6'h23) begin
          c = '0; c.mem_2_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1;
          push(c, rnd_bit(), (k < drop), op, 1'b1); k++;
        end
      end
      6'h04: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = A_SUB; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.instr_done = 1'b1;
        push(c, rnd_bit(), (k < drop), op, 1'b1); k++;
      end
      6'h02: begin
        c = '0; c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
        push(c, rnd_bit(), (k < drop), op, 1'b1); k++;
      end
      default: begin
        m_ill = 1'b1;
        push('0, rnd_bit(), (k < drop), op, 1'b0); k++;
      end
    endcase
    last_en = ((k - 1) < drop);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; bus.en = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 6'h00;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({observed(), bus.retired, bus.illegal_op} !== {17'd0, 32'd0, 1'b0})
      $display("FAIL reset_state: got ctl=%h retired=%0d illegal=%b, want ctl=0 retired=0 illegal=0",
               observed(), bus.retired, bus.illegal_op);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.en = 1'b0;
    @(negedge clk);
    checks++;
    if ({observed(), bus.retired, bus.illegal_op} !== {17'd0, 32'd0, 1'b0})
      $display("FAIL idle_no_en: got ctl=%h retired=%0d illegal=%b, want ctl=0 retired=0 illegal=0",
               observed(), bus.retired, bus.illegal_op);
    else passed++;
    @(posedge clk); #1;
    m_ret = 32'd0; m_ill = 1'b0;
  endtask

  task automatic test_r_type();
    step_t s; ctl_t o; logic le; int n;
    add_idle(1, 1'b1);
    add_instr(6'h00, 0, 0, 99, le);
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.en = s.en; bus.mem_ready = s.mr; bus.opcode = s.op; bus.zero = rnd_bit();
      @(negedge clk); o = observed(); checks++;
      if ({o, bus.retired, bus.illegal_op} !== {s.exp, s.ret, s.ill})
        $display("FAIL r_type cyc %0d: got ctl=%h retired=%0d illegal=%b, want ctl=%h retired=%0d illegal=%b",
                 n, o, bus.retired, bus.illegal_op, s.exp, s.ret, s.ill);
      else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    step_t s; ctl_t o; logic le; int n;
    add_instr(6'h23, 0, 2, 99, le);
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.en = s.en; bus.mem_ready = s.mr; bus.opcode = s.op; bus.zero = rnd_bit();
      @(negedge clk); o = observed(); checks++;
      if ({o, bus.retired, bus.illegal_op} !== {s.exp, s.ret, s.ill})
        $display("FAIL lw_wait cyc %0d: got ctl=%h retired=%0d illegal=%b, want ctl=%h retired=%0d illegal=%b",
                 n, o, bus.retired, bus.illegal_op, s.exp, s.ret, s.ill);
      else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_branch_jump();
    step_t s; ctl_t o; logic le; int n;
    add_instr(6'h2B, 0, 0, 99, le);
    add_instr(6'h2B, 1, 2, 99, le);
    add_instr(6'h04, 0, 0, 99, le);
    add_instr(6'h02, 0, 0, 99, le);
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.en = s.en; bus.mem_ready = s.mr; bus.opcode = s.op; bus.zero = rnd_bit();
      @(negedge clk); o = observed(); checks++;
      if ({o, bus.retired, bus.illegal_op} !== {s.exp, s.ret, s.ill})
        $display("FAIL sw_beq_j cyc %0d: got ctl=%h retired=%0d illegal=%b, want ctl=%h retired=%0d illegal=%b",
                 n, o, bus.retired, bus.illegal_op, s.exp, s.ret, s.ill);
      else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_en_drop();
    step_t s; ctl_t o; logic le; int n;
    add_instr(6'h00, 0, 0, 2, le);   // en falls as EXEC_R is entered
    add_idle(3, 1'b0);
    add_idle(1, 1'b1);
    add_instr(6'h08, 0, 0, 99, le);
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.en = s.en; bus.mem_ready = s.mr; bus.opcode = s.op; bus.zero = rnd_bit();
      @(negedge clk); o = observed(); checks++;
      if ({o, bus.retired, bus.illegal_op} !== {s.exp, s.ret, s.ill})
        $display("FAIL en_drop cyc %0d: got ctl=%h retired=%0d illegal=%b, want ctl=%h retired=%0d illegal=%b",
                 n, o, bus.retired, bus.illegal_op, s.exp, s.ret, s.ill);
      else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    step_t s; ctl_t o; logic le; int n;
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    for (int i = 0; i < 24; i++) begin
      add_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 99, le);
      if (!le) begin
        add_idle($urandom_range(0, 2), 1'b0);
        add_idle(1, 1'b1);
      end
    end
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.en = s.en; bus.mem_ready = s.mr; bus.opcode = s.op; bus.zero = rnd_bit();
      @(negedge clk); o = observed(); checks++;
      if ({o, bus.retired, bus.illegal_op} !== {s.exp, s.ret, s.ill})
        $display("FAIL back_to_back cyc %0d: got ctl=%h retired=%0d illegal=%b, want ctl=%h retired=%0d illegal=%b",
                 n, o, bus.retired, bus.illegal_op, s.exp, s.ret, s.ill);
      else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    step_t s; ctl_t o; logic le; int n;
    add_instr(6'h3F, 0, 0, 99, le);
    add_instr(6'h00, 1, 0, 99, le);
    add_instr(6'h08, 0, 0, 99, le);
    add_instr(6'h15, 0, 0, 99, le);
    add_instr(6'h04, 0, 0, 99, le);
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.en = s.en; bus.mem_ready = s.mr; bus.opcode = s.op; bus.zero = rnd_bit();
      @(negedge clk); o = observed(); checks++;
      if ({o, bus.retired, bus.illegal_op} !== {s.exp, s.ret, s.ill})
        $display("FAIL illegal cyc %0d: got ctl=%h retired=%0d illegal=%b, want ctl=%h retired=%0d illegal=%b",
                 n, o, bus.retired, bus.illegal_op, s.exp, s.ret, s.ill);
      else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    step_t s; ctl_t o; logic le; int n;
    add_instr(6'h23, 0, 5, 99, le);
    // Play FETCH, DECODE, MEM_ADDR and two MEM_RD wait cycles; reset on the second
    for (n = 0; n < 5; n++) begin
      s = q.pop_front();
      bus.en = s.en; bus.mem_ready = s.mr; bus.opcode = s.op; bus.zero = rnd_bit();
      if (n == 4) begin rst_n = 1'b0; bus.mem_ready = 1'b1; end
      @(negedge clk); o = observed(); checks++;
      if ({o, bus.retired, bus.illegal_op} !== {s.exp, s.ret, s.ill})
        $display("FAIL reset_mid cyc %0d: got ctl=%h retired=%0d illegal=%b, want ctl=%h retired=%0d illegal=%b",
                 n, o, bus.retired, bus.illegal_op, s.exp, s.ret, s.ill);
      else passed++;
      @(posedge clk); #1;
    end
    q.delete();
    rst_n = 1'b1; bus.en = 1'b0; bus.mem_ready = 1'b1;
    @(negedge clk); checks++;
    if ({observed(), bus.retired, bus.illegal_op} !== {17'd0, 32'd0, 1'b0})
      $display("FAIL reset_mid_after: got ctl=%h retired=%0d illegal=%b, want ctl=0 retired=0 illegal=0",
               observed(), bus.retired, bus.illegal_op);
    else passed++;
    @(posedge clk); #1;
    m_ret = 32'd0; m_ill = 1'b0;
    // Recovery: one jump with en low throughout, ending in IDLE
    add_idle(1, 1'b1);
    add_instr(6'h02, 0, 0, 0, le);
    add_idle(2, 1'b0);
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.en = s.en; bus.mem_ready = s.mr; bus.opcode = s.op; bus.zero = rnd_bit();
      @(negedge clk); o = observed(); checks++;
      if ({o, bus.retired, bus.illegal_op} !== {s.exp, s.ret, s.ill})
        $display("FAIL recovery cyc %0d: got ctl=%h retired=%0d illegal=%b, want ctl=%h retired=%0d illegal=%b",
                 n, o, bus.retired, bus.illegal_op, s.exp, s.ret, s.ill);
      else passed++;
      n++; @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.en = 1'b0; bus.opcode = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    m_ret = 32'd0; m_ill = 1'b0;
    test_reset();
    test_r_type();
    test_lw_wait();
    test_sw_branch_jump();
    test_en_drop();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Sequencing FSM for the multicycle MIPS datapath. Each instruction runs as a series of states: fetch, decode, execute, memory and writeback. In each state the block drives the shared ALU, memory port, IR, PC and register-file controls. It waits on a memory ready handshake, counts retired instructions and flags unsupported opcodes.

Parameters:
CNT_W, 32, width of retired-instruction counter
ADD_OPCODE, 2'd0, alu_op value for add
SUB_OPCODE, 2'd1, alu_op value for subtract
R_TYPE_OPCODE, 2'd2, alu_op value for funct-decoded R-type

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
en  in  1  run enable
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_2_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
reg_dst  out  1  write register: 1 = rd, 0 = rt
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = rs register A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
alu_op  out  2  ADD/SUB/R_TYPE
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse in last state of each instruction
illegal_op  out  1  sticky flag, unsupported opcode seen
retired  out  CNT_W  count of completed instructions
state  out  4  current state, for debug

Behaviour:
- Sync reset (rst_n=0 at clk edge): state=IDLE, retired=0, illegal_op=0. All control outputs 0, alu_op=ADD_OPCODE. Reset overrides mid-instruction: pending memory access is abandoned, no PC/IR/regfile write.
- Control outputs are decoded from state (Moore). Exception: ir_write and pc_write in FETCH are also gated by mem_ready. Any control not listed for a state is 0.
- IDLE: no controls asserted. If en=1, next state is FETCH.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1, pc_write=1, next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (precompute branch target). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x08 -> EXEC_I
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - otherwise -> BAD
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=R_TYPE. Next: R_WB.
- R_WB: reg_dst=1, mem_2_reg=0, reg_write=1, instr_done=1.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next: I_WB.
- I_WB: reg_dst=0, mem_2_reg=0, reg_write=1, instr_done=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next: MEM_RD if opcode=0x23, else MEM_WR.
- MEM_RD: iord=1, mem_read=1. Holds until mem_ready=1, then next state is MEM_WB.
- MEM_WB: reg_dst=0, mem_2_reg=1, reg_write=1, instr_done=1.
- MEM_WR: iord=1, mem_write=1. Holds until mem_ready=1; instr_done=1 only on the cycle mem_ready=1, then instruction ends.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_source=01, instr_done=1.
- JUMP: pc_write=1, pc_source=10, instr_done=1.
- BAD: illegal_op set to 1 (sticky until reset), instr_done=0, retired unchanged; PC already advanced, so the instruction is skipped.
- End of instruction (any state with instr_done, and BAD): next state is FETCH if en=1, else IDLE. Deassertion of en never aborts an instruction in flight.
- retired increments by 1 on each instr_done cycle and wraps modulo 2^CNT_W.
- mem_read and mem_write are never both 1.
- Latency with zero memory wait: R=4, ADDI=4, LW=5, SW=4, BEQ=3, J=3 cycles. Each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds 1.

Test Plan:
- Reset then en=1, mem_ready tied 1, opcode=0x00 -> states FETCH,DECODE,EXEC_R,R_WB. reg_write=1 and reg_dst=1 only in cycle 4; instr_done pulses once; retired=1.
- opcode=0x23, mem_ready low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles with iord=1, mem_read=1. mem_2_reg=1, reg_write=1 in MEM_WB; total 7 cycles.
- opcode=0x2B, mem_ready=1 -> mem_write=1 for exactly 1 cycle, iord=1, reg_write never 1; 4 cycles.
- opcode=0x04, then 0x02 -> BEQ in 3 cycles with alu_op=SUB, pc_write_cond=1, pc_source=01. J in 3 cycles with pc_write=1, pc_source=10; retired=2.
- opcode=0x3F -> BAD state, illegal_op=1 and stays 1 over following legal instructions; retired unchanged; next state FETCH.
- Drop en during EXEC_R -> R_WB completes, then IDLE. Assert rst_n=0 during MEM_RD wait -> next cycle IDLE, all outputs 0, retired=0, illegal_op=0.
